smart_toilet_dosing_ctrl: RTL and testbench

Sequencer upstream of the smart_toilet_r fluidic netlist. It drives the three inlet pumps and valves that feed soln1, soln2 and soln3. Inlet starts are staggered so that the long soln3 serpentine path, the shorter soln2 path and the direct soln1 path reach the mixers in order. After dosing it runs a flush of the outlet path.

---
 rtl/smart_toilet_dosing_ctrl_pkg.sv | 17 +
 rtl/smart_toilet_dosing_ctrl_if.sv | 35 +++
 rtl/smart_toilet_dosing_ctrl_dose_channel.sv | 50 +++++
 rtl/smart_toilet_dosing_ctrl.sv | 118 +++++++++++
 tb/tb_smart_toilet_dosing_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/smart_toilet_dosing_ctrl_pkg.sv
// Shared types and constants for the smart_toilet inlet dosing sequencer.
package smart_toilet_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam int SOLN1 = 0;
    localparam int SOLN2 = 1;
    localparam int SOLN3 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DOSE  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/smart_toilet_dosing_ctrl_if.sv
// Run request / pump and valve drive bundle between the host and the dosing sequencer.
interface smart_toilet_dosing_ctrl_if
    import smart_toilet_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             start;
    logic             ready;
    logic [CNT_W-1:0] vol1;
    logic [CNT_W-1:0] vol2;
    logic [CNT_W-1:0] vol3;
    logic [CNT_W-1:0] off32;
    logic [CNT_W-1:0] off21;
    logic [CNT_W-1:0] flush_len;
    logic             abort;
    logic [2:0]       pump_step;
    logic [2:0]       valve_open;
    logic             flush_step;
    logic             flush_valve;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, vol1, vol2, vol3, off32, off21, flush_len, abort,
        input  ready, pump_step, valve_open, flush_step, flush_valve, busy, done, aborted
    );

    modport slave (
        input  start, vol1, vol2, vol3, off32, off21, flush_len, abort,
        output ready, pump_step, valve_open, flush_step, flush_valve, busy, done, aborted
    );

endinterface

// File: rtl/smart_toilet_dosing_ctrl_dose_channel.sv
// One inlet: tick-based delay down-counter, then a step down-counter that emits pump pulses.
module dose_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W+1:0] delay,
    input  logic [CNT_W-1:0] vol,
    output logic             step,
    output logic             valve,
    output logic             finishing
);

    logic [CNT_W+1:0] dly_cnt;
    logic [CNT_W-1:0] rem_cnt;
    logic             fire;

    assign fire = tick && (dly_cnt == '0) && (rem_cnt != '0);

    // True when this inlet has no steps left after the current tick.
    assign finishing = (rem_cnt == '0) || ((dly_cnt == '0) && (rem_cnt == CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt <= '0;
            rem_cnt <= '0;
            step    <= 1'b0;
            valve   <= 1'b0;
        end else if (load) begin
            dly_cnt <= delay;
            rem_cnt <= vol;
            step    <= 1'b0;
            valve   <= 1'b0;
        end else begin
            step <= fire;
            if (fire) begin
                rem_cnt <= rem_cnt - CNT_W'(1);
                valve   <= 1'b1;
            end else if (rem_cnt == '0) begin
                valve   <= 1'b0;
            end
            if (tick && (dly_cnt != '0)) begin
                dly_cnt <= dly_cnt - (CNT_W+2)'(1);
            end
        end
    end

endmodule

// File: rtl/smart_toilet_dosing_ctrl.sv
// Staggered soln3/soln2/soln1 inlet dosing followed by an outlet flush.
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   DOSE  | inlet channels stepping on divider ticks
//   FLUSH | outlet flush pump stepping for flush_len ticks
//   DONE  | one-cycle completion, done=1
module smart_toilet_dosing_ctrl
    import smart_toilet_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int STEP_DIV = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    smart_toilet_dosing_ctrl_if.slave   bus
);

    localparam int DIV_W = $clog2(STEP_DIV);

    state_t           state, next_state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] fl_rem;
    logic             running, tick, accept, kill, chan_load;
    logic [2:0]       step, valve, fin;
    logic [CNT_W+1:0] dly_in [3];
    logic [CNT_W-1:0] vol_in [3];

    assign running   = (state == DOSE) || (state == FLUSH);
    assign tick      = running && (div_cnt == '0);
    assign accept    = (state == IDLE) && bus.start && !bus.abort;
    assign kill      = (state != IDLE) && bus.abort;
    assign chan_load = accept || kill;

    // Abort reloads every channel with zeros, which also clears its outputs.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dly_in[i] = '0;
            vol_in[i] = '0;
        end
        if (!kill) begin
            vol_in[SOLN1] = bus.vol1;
            vol_in[SOLN2] = bus.vol2;
            vol_in[SOLN3] = bus.vol3;
            dly_in[SOLN2] = (CNT_W+2)'(bus.off32);
            dly_in[SOLN1] = (CNT_W+2)'(bus.off32) + (CNT_W+2)'(bus.off21);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_chan
        dose_channel #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .load      (chan_load),
            .delay     (dly_in[g]),
            .vol       (vol_in[g]),
            .step      (step[g]),
            .valve     (valve[g]),
            .finishing (fin[g])
        );
    end

    assign bus.pump_step  = step;
    assign bus.valve_open = valve;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = DOSE;
            DOSE:    if (tick && (&fin)) next_state = FLUSH;
            FLUSH:   if (fl_rem == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (kill) next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            div_cnt         <= '0;
            fl_rem          <= '0;
            bus.flush_step  <= 1'b0;
            bus.flush_valve <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.aborted     <= 1'b0;
            bus.ready       <= 1'b1;
        end else begin
            state <= next_state;

            if (accept) begin
                div_cnt <= DIV_W'(STEP_DIV - 1);
            end else if (kill) begin
                div_cnt <= '0;
            end else if (running) begin
                div_cnt <= (div_cnt == '0) ? DIV_W'(STEP_DIV - 1) : div_cnt - DIV_W'(1);
            end

            bus.flush_step <= 1'b0;
            if (accept) begin
                fl_rem <= bus.flush_len;
            end else if (kill) begin
                fl_rem <= '0;
            end else if ((state == FLUSH) && tick && (fl_rem != '0)) begin
                fl_rem         <= fl_rem - CNT_W'(1);
                bus.flush_step <= 1'b1;
            end

            bus.flush_valve <= (next_state == FLUSH);
            bus.busy        <= (next_state == DOSE) || (next_state == FLUSH);
            bus.done        <= (next_state == DONE);
            bus.ready       <= (next_state == IDLE);
            bus.aborted     <= kill;
        end
    end

endmodule

// File: tb/tb_smart_toilet_dosing_ctrl.sv
// Directed bench for smart_toilet_dosing_ctrl with STEP_DIV=4, cycle-exact expected outputs.
module tb_smart_toilet_dosing_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    smart_toilet_dosing_ctrl_if #(.CNT_W(16)) bus ();

    smart_toilet_dosing_ctrl #(.CNT_W(16), .STEP_DIV(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // {pump_step, valve_open, flush_step, flush_valve, done, ready, busy}
    function automatic logic [10:0] obs();
        return {bus.pump_step, bus.valve_open, bus.flush_step, bus.flush_valve,
                bus.done, bus.ready, bus.busy};
    endfunction

    // Hand-derived profile of the vol3=5 vol2=3 vol1=2 off32=1 off21=1 flush_len=2 run.
    function automatic logic [10:0] exp_run(input int c, input bit no2);
        logic [2:0] p, v;
        p[2] = (c == 5) || (c == 9) || (c == 13) || (c == 17) || (c == 21);
        p[1] = !no2 && ((c == 9) || (c == 13) || (c == 17));
        p[0] = (c == 13) || (c == 17);
        v[2] = (c >= 5) && (c <= 21);
        v[1] = !no2 && (c >= 9) && (c <= 17);
        v[0] = (c >= 13) && (c <= 17);
        return {p, v, (c == 25) || (c == 29), (c >= 21) && (c <= 29), c == 30,
                c >= 31, (c >= 1) && (c <= 29)};
    endfunction

    function automatic logic [10:0] exp_zero(input int c);
        return {6'b0, 1'b0, c == 5, c == 6, c >= 7, (c >= 1) && (c <= 5)};
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_run(input int v1, input int v2, input int v3,
                           input int o32, input int o21, input int fl);
        bus.vol1      = 16'(v1);
        bus.vol2      = 16'(v2);
        bus.vol3      = 16'(v3);
        bus.off32     = 16'(o32);
        bus.off21     = 16'(o21);
        bus.flush_len = 16'(fl);
    endtask

    // Leaves the bench sampling cycle 1 of the run.
    task automatic start_run(input bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        next_cyc();
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic run_zero(input string tag);
        set_run(0, 0, 0, 0, 0, 0);
        start_run(1'b0);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("%s c%0d", tag, c), obs(), exp_zero(c));
            next_cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_run(0, 0, 0, 0, 0, 0);
        next_cyc();
        next_cyc();
        chk("reset outs", {obs(), bus.aborted}, {11'b000_000_0_0_0_1_0, 1'b0});
        rst = 1'b0;
        next_cyc();

        // Nominal staggered run
        set_run(2, 3, 5, 1, 1, 2);
        start_run(1'b0);
        for (int c = 1; c <= 32; c++) begin
            chk($sformatf("nominal c%0d", c), obs(), exp_run(c, 1'b0));
            next_cyc();
        end

        // All volumes zero, no flush
        run_zero("zero");

        // Abort mid-dose, then a fresh run
        set_run(2, 3, 5, 1, 1, 2);
        start_run(1'b0);
        for (int c = 1; c <= 9; c++) next_cyc();
        chk("pre-abort c10", obs(), exp_run(10, 1'b0));
        bus.abort = 1'b1;
        next_cyc();
        bus.abort = 1'b0;
        chk("abort c11", {obs(), bus.aborted}, {11'b000_000_0_0_0_1_0, 1'b1});
        next_cyc();
        chk("abort pulse width", bus.aborted, 1'b0);
        bus.abort = 1'b1;
        next_cyc();
        bus.abort = 1'b0;
        chk("idle abort ignored", {bus.aborted, bus.ready, bus.busy}, 3'b010);
        run_zero("post-abort");

        // start held through a whole run
        set_run(2, 3, 5, 1, 1, 2);
        start_run(1'b1);
        for (int c = 1; c <= 31; c++) begin
            chk($sformatf("held c%0d", c), obs(), exp_run(c, 1'b0));
            next_cyc();
        end
        bus.start = 1'b0;
        chk("held re-accept", {bus.ready, bus.busy}, 2'b01);
        for (int c = 33; c <= 36; c++) next_cyc();
        chk("held 2nd run pump", bus.pump_step, 3'b100);
        bus.abort = 1'b1;
        next_cyc();
        bus.abort = 1'b0;
        chk("held cleanup abort", bus.aborted, 1'b1);
        next_cyc();

        // Synchronous reset mid-dose
        set_run(2, 3, 5, 1, 1, 2);
        start_run(1'b0);
        for (int c = 1; c <= 13; c++) next_cyc();
        chk("pre-rst c14", obs(), exp_run(14, 1'b0));
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        chk("rst c15", {obs(), bus.aborted}, {11'b000_000_0_0_0_1_0, 1'b0});
        next_cyc();
        chk("rst c16 idle", obs(), 11'b000_000_0_0_0_1_0);

        // soln2 skipped; soln1 window unchanged
        set_run(2, 0, 5, 1, 1, 2);
        start_run(1'b0);
        for (int c = 1; c <= 32; c++) begin
            chk($sformatf("no-soln2 c%0d", c), obs(), exp_run(c, 1'b1));
            next_cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
